aes_key_schedule: RTL
=====================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter Nb, default 4, number of state columns.
REQ-002 SHALL have parameter Nk, default 4, number of 32-bit words in the cipher key; only 4 is supported.
REQ-003 SHALL have parameter Nr, default 10, number of rounds.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_valid, input, 1 bit: a cipher key is offered.
REQ-007 SHALL have port key_ready, output, 1 bit: the block can accept a key.
REQ-008 SHALL have port key, input, 128 bits: cipher key, with byte 0 at key[127:120].
REQ-009 SHALL have port busy, output, 1 bit: expansion is in progress.
REQ-010 SHALL have port keys_valid, output, 1 bit: all 11 round keys for the last accepted key are stored.
REQ-011 SHALL have port rk_rd_en, input, 1 bit: round-key read request.
REQ-012 SHALL have port rk_idx, input, 4 bits: round number to read, 0..10.
REQ-013 SHALL have port rk_out, output, 128 bits: round key, words w[4r]..w[4r+3], with w[4r] at rk_out[127:96].
REQ-014 SHALL have port rk_out_valid, output, 1 bit: rk_out holds read data.

Function
REQ-015 SHALL implement an FSM with states IDLE, EXPAND and DONE, and store 44 x 32-bit words w[0..43].
REQ-016 SHALL drive key_ready=1 in IDLE and DONE, and key_ready=0 in EXPAND.
REQ-017 SHALL accept the key on a rising edge with key_valid && key_ready (the accept edge E0).
- On E0: write w[0..3] = key; set word counter i=4; go to EXPAND; clear keys_valid.
REQ-018 SHALL compute one word per clock in EXPAND, for i=4..43, on edges E1..E40.
- Rule: w[i] = w[i-4] ^ temp, where temp = w[i-1].
- When i%4==0: temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/4].
REQ-019 SHALL define RotWord as [a0,a1,a2,a3] -> [a1,a2,a3,a0], where a0 is the most significant byte.
REQ-020 SHALL define SubWord as the forward FIPS-197 S-box applied to each byte; the inverse S-box SHALL NOT be used here.
REQ-021 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the most significant byte with the other three bytes zero.
REQ-022 SHALL, on E40 (the edge that writes w[43]): go to DONE, set keys_valid=1 and set busy=0.
- Latency: keys_valid is high 40 cycles after the accept edge.
REQ-023 SHALL drive busy=1 exactly while in EXPAND.
REQ-024 SHALL, when a key is accepted in DONE: restart expansion from E0 with the new key, and deassert keys_valid starting the cycle after E0.
REQ-025 SHALL service a read on an edge with rk_rd_en=1 and keys_valid=1, as follows:
- Next cycle: rk_out = round key rk_idx and rk_out_valid=1.
- Latency: 1 cycle; a new read is allowed every cycle.
REQ-026 SHALL, for a read with rk_idx > 10, return rk_out = 0 with rk_out_valid=1.
REQ-027 SHALL ignore rk_rd_en while keys_valid=0; rk_out_valid=0 the next cycle and rk_out holds its value.
REQ-028 SHALL drive rk_out_valid=0 on any cycle that does not follow an accepted read.
REQ-029 SHALL, for a read on the same edge as a new key accept in DONE: return the old key's round key, since the stored words are unchanged until E1.
- Note: the write on E0 overwrites w[0..3], so a read at E0 SHALL return the pre-edge contents.
REQ-030 SHALL ignore key_valid while in EXPAND; the offered key is not captured.

Reset
REQ-031 SHALL, while rst_n=0, immediately and asynchronously force:
- state=IDLE, i=4;
- key_ready=1, busy=0, keys_valid=0;
- rk_out=0, rk_out_valid=0;
- w[0..43]=0.
REQ-032 SHALL, on reset asserted mid-EXPAND: abandon the expansion, keep keys_valid=0, and accept a new key on the first edge after release.

Verification
REQ-033 SHALL cover key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid 40 cycles after accept; expected reads:
- rk_idx 0 -> 2b7e151628aed2a6abf7158809cf4f3c.
- rk_idx 1 -> a0fafe1788542cb123a339392a6c7605.
- rk_idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL cover the all-zero key; expected reads:
- rk_idx 1 -> 62636363626363636263636362636363.
- rk_idx 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 SHALL cover back-to-back reads of rk_idx 10,9,...,0 on consecutive cycles -> rk_out_valid high for 11 cycles with the matching keys, each one cycle late; then rk_idx 15 -> rk_out=0, rk_out_valid=1.
REQ-036 SHALL cover rk_rd_en during EXPAND, and key_valid during EXPAND with a different key -> no rk_out_valid pulse; the final keys match the first key only.
REQ-037 SHALL cover rst_n pulsed low at cycle 20 of EXPAND -> all outputs return to reset values immediately; a subsequent FIPS-197 key completes correctly.
REQ-038 SHALL cover a new key accepted in DONE with a simultaneous read of rk_idx 10 -> old round key 10 returned; keys_valid low for 40 cycles, then new keys readable.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: accepts a cipher key, derives the 44 schedule words one per
// clock, and serves 128-bit round keys through a one-cycle registered read port.
module aes_key_schedule #(
  parameter int Nb = 4,
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_out_valid
);

  localparam int         NW         = Nb * (Nr + 1);
  localparam logic [5:0] FIRST_WORD = 6'(Nk);
  localparam logic [5:0] LAST_WORD  = 6'(NW - 1);
  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_r;
  logic [5:0]     i_r;
  logic [31:0]    w_r [0:NW-1];
  logic           key_ready_r;
  logic           busy_r;
  logic           keys_valid_r;
  logic [127:0]   rk_out_r;
  logic           rk_out_valid_r;

  logic [31:0]    prev_word_s;
  logic [31:0]    temp_s;
  logic [31:0]    next_word_s;
  logic [5:0]     rd_base_s;
  logic [127:0]   rd_data_s;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (a^254, zero maps to zero) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t = a;
    for (int k = 0; k < 6; k++) begin
      t = gf_mul(gf_mul(t, t), a);
    end
    inv = gf_mul(t, t);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Next schedule word w[i] from w[i-1] and w[i-Nk].
  always_comb begin
    prev_word_s = w_r[i_r - 6'd1];
    if (i_r[1:0] == 2'b00) begin
      temp_s = sub_word(rot_word(prev_word_s)) ^ {rcon(i_r[5:2]), 24'h000000};
    end else begin
      temp_s = prev_word_s;
    end
    next_word_s = w_r[i_r - FIRST_WORD] ^ temp_s;
  end

  // Round-key gather; out-of-range rounds read as zero.
  always_comb begin
    rd_base_s = {rk_idx, 2'b00};
    if (rk_idx <= LAST_ROUND) begin
      rd_data_s = {w_r[rd_base_s], w_r[rd_base_s + 6'd1],
                   w_r[rd_base_s + 6'd2], w_r[rd_base_s + 6'd3]};
    end else begin
      rd_data_s = 128'h0;
    end
  end

  // Control FSM and word store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      i_r          <= FIRST_WORD;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      for (int k = 0; k < NW; k++) begin
        w_r[k] <= 32'h0;
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (key_valid && key_ready_r) begin
            for (int k = 0; k < Nk; k++) begin
              w_r[k] <= key[127 - 32*k -: 32];
            end
            i_r          <= FIRST_WORD;
            state_r      <= EXPAND;
            key_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            keys_valid_r <= 1'b0;
          end
        end
        EXPAND: begin
          w_r[i_r] <= next_word_s;
          if (i_r == LAST_WORD) begin
            i_r          <= FIRST_WORD;
            state_r      <= DONE;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b1;
          end else begin
            i_r <= i_r + 6'd1;
          end
        end
        default: begin
          state_r      <= IDLE;
          i_r          <= FIRST_WORD;
          key_ready_r  <= 1'b1;
          busy_r       <= 1'b0;
          keys_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Read port: rk_out holds its last value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_r       <= 128'h0;
      rk_out_valid_r <= 1'b0;
    end else if (rk_rd_en && keys_valid_r) begin
      rk_out_r       <= rd_data_s;
      rk_out_valid_r <= 1'b1;
    end else begin
      rk_out_valid_r <= 1'b0;
    end
  end

  assign key_ready    = key_ready_r;
  assign busy         = busy_r;
  assign keys_valid   = keys_valid_r;
  assign rk_out       = rk_out_r;
  assign rk_out_valid = rk_out_valid_r;

endmodule
